// File: rtl/lsu_axi4lite_bridge_pkg.sv
// Purpose: shared types and constants for the LSU to AXI4-Lite bridge.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package lsu_axi4lite_bridge_pkg;

    // Request tag width, shared with the LSU
    localparam int TAG_W = 11;

    // AXI response codes
    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    // Bridge sequencing states
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WR_REQ   = 3'd1,
        ST_WR_RESP  = 3'd2,
        ST_RD_ADDR  = 3'd3,
        ST_RD_DATA  = 3'd4,
        ST_CMO_ACK  = 3'd5,
        ST_DRAIN    = 3'd6
    } bridge_state_t;

endpackage

// File: rtl/lsu_axi4lite_bridge_watchdog.sv
// Purpose: bus timeout counter; flags expiry when an outstanding access has waited too long.
// Latency: expire_o is combinational from the count, asserted while count == TIMEOUT_CYCLES-1.
// Backpressure: none; counts only while en_i is high, TIMEOUT_CYCLES == 0 never expires.
module lsu_bus_watchdog #(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int TIMEOUT_W      = 11
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);

    localparam logic [TIMEOUT_W-1:0] LAST_CNT =
        (TIMEOUT_CYCLES == 0) ? '0 : TIMEOUT_W'(TIMEOUT_CYCLES - 1);

    logic [TIMEOUT_W-1:0] cnt_q;

    // Count cycles of an outstanding access; clearing wins over counting
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (en_i) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign expire_o = (TIMEOUT_CYCLES != 0) && en_i && (cnt_q == LAST_CNT);

endmodule

// File: rtl/lsu_axi4lite_bridge.sv
// Purpose: converts the LSU single-outstanding request port into an AXI4-Lite master with a timeout.
// Latency: AXI valids one cycle after accept; ack one cycle after the R/B handshake (3 cycles min per request).
// Backpressure: accept only in IDLE; AXI valids held until handshake, even across a timeout (DRAIN).
module lsu_axi4lite_bridge
    import lsu_axi4lite_bridge_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int TIMEOUT_W      = 11
) (
    input  logic             clk_i,
    input  logic             rst_i,

    input  logic [31:0]      mem_addr_i,
    input  logic [31:0]      mem_data_wr_i,
    input  logic             mem_rd_i,
    input  logic [3:0]       mem_wr_i,
    input  logic             mem_cacheable_i,
    input  logic [TAG_W-1:0] mem_req_tag_i,
    input  logic             mem_invalidate_i,
    input  logic             mem_writeback_i,
    input  logic             mem_flush_i,
    output logic             mem_accept_o,
    output logic             mem_ack_o,
    output logic             mem_error_o,
    output logic [31:0]      mem_data_rd_o,
    output logic [TAG_W-1:0] mem_resp_tag_o,
    output logic             mem_load_fault_o,
    output logic             mem_store_fault_o,

    output logic             axi_awvalid_o,
    output logic [31:0]      axi_awaddr_o,
    output logic [2:0]       axi_awprot_o,
    input  logic             axi_awready_i,
    output logic             axi_wvalid_o,
    output logic [31:0]      axi_wdata_o,
    output logic [3:0]       axi_wstrb_o,
    input  logic             axi_wready_i,
    input  logic             axi_bvalid_i,
    input  logic [1:0]       axi_bresp_i,
    output logic             axi_bready_o,
    output logic             axi_arvalid_o,
    output logic [31:0]      axi_araddr_o,
    output logic [2:0]       axi_arprot_o,
    input  logic             axi_arready_i,
    input  logic             axi_rvalid_i,
    input  logic [31:0]      axi_rdata_i,
    input  logic [1:0]       axi_rresp_i,
    output logic             axi_rready_o
);

    bridge_state_t    state_q, state_d;

    // Captured request
    logic [31:0]      addr_q;
    logic [31:0]      wdata_q;
    logic [3:0]       wstrb_q;
    logic [TAG_W-1:0] tag_q;
    logic             is_wr_q;

    // Per-channel handshake completion for the current access
    logic             aw_done_q, w_done_q, ar_done_q;

    // Registered response
    logic             ack_q, err_q;
    logic [31:0]      rdata_q;
    logic [TAG_W-1:0] resp_tag_q;

    logic             req_wr, req_rd, req_cmo, take;
    logic             aw_hs, w_hs, ar_hs, b_hs, r_hs;
    logic             wd_en, wd_expire, resp_done, timeout;
    logic             ack_set, ack_err;
    logic [31:0]      ack_data;
    logic             wr_phase, rd_phase;
    logic             unused_ok;

    assign req_wr  = |mem_wr_i;
    assign req_rd  = mem_rd_i;
    assign req_cmo = mem_invalidate_i | mem_writeback_i | mem_flush_i;
    assign take    = mem_accept_o & (req_wr | req_rd | req_cmo);

    assign aw_hs = axi_awvalid_o & axi_awready_i;
    assign w_hs  = axi_wvalid_o  & axi_wready_i;
    assign ar_hs = axi_arvalid_o & axi_arready_i;
    assign b_hs  = axi_bvalid_i  & axi_bready_o;
    assign r_hs  = axi_rvalid_i  & axi_rready_o;

    assign wd_en = (state_q == ST_WR_REQ)  || (state_q == ST_WR_RESP) ||
                   (state_q == ST_RD_ADDR) || (state_q == ST_RD_DATA);

    lsu_bus_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .TIMEOUT_W      (TIMEOUT_W)
    ) u_watchdog (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .clr_i    (mem_accept_o),
        .en_i     (wd_en),
        .expire_o (wd_expire)
    );

    // A response arriving in the expiry cycle takes precedence over the timeout
    assign resp_done = ((state_q == ST_WR_RESP) && b_hs) || ((state_q == ST_RD_DATA) && r_hs);
    assign timeout   = wd_expire & ~resp_done;

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state selection; write beats read beats CMO when several are presented
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (take) begin
                    if (req_wr)      state_d = ST_WR_REQ;
                    else if (req_rd) state_d = ST_RD_ADDR;
                    else             state_d = ST_CMO_ACK;
                end
            end
            ST_WR_REQ: begin
                if (timeout)                                          state_d = ST_DRAIN;
                else if ((aw_done_q | aw_hs) && (w_done_q | w_hs))    state_d = ST_WR_RESP;
            end
            ST_WR_RESP: begin
                if (b_hs)         state_d = ST_IDLE;
                else if (timeout) state_d = ST_DRAIN;
            end
            ST_RD_ADDR: begin
                if (timeout)    state_d = ST_DRAIN;
                else if (ar_hs) state_d = ST_RD_DATA;
            end
            ST_RD_DATA: begin
                if (r_hs)         state_d = ST_IDLE;
                else if (timeout) state_d = ST_DRAIN;
            end
            ST_CMO_ACK: state_d = ST_IDLE;
            ST_DRAIN: begin
                if (is_wr_q ? b_hs : r_hs) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // AXI channel controls, accept, and the response about to be registered
    always_comb begin
        wr_phase      = (state_q == ST_WR_REQ) || ((state_q == ST_DRAIN) && is_wr_q);
        rd_phase      = (state_q == ST_RD_ADDR) || ((state_q == ST_DRAIN) && !is_wr_q);
        mem_accept_o  = (state_q == ST_IDLE);
        axi_awvalid_o = wr_phase & ~aw_done_q;
        axi_wvalid_o  = wr_phase & ~w_done_q;
        axi_bready_o  = (state_q == ST_WR_RESP) || ((state_q == ST_DRAIN) && is_wr_q);
        axi_arvalid_o = rd_phase & ~ar_done_q;
        axi_rready_o  = (state_q == ST_RD_DATA) || ((state_q == ST_DRAIN) && !is_wr_q);

        ack_set  = resp_done || (state_q == ST_CMO_ACK) || timeout;
        ack_err  = 1'b0;
        ack_data = 32'h0;
        if (timeout) begin
            ack_err = 1'b1;
        end else if ((state_q == ST_RD_DATA) && r_hs) begin
            ack_err  = (axi_rresp_i != AXI_RESP_OKAY);
            ack_data = ack_err ? 32'h0 : axi_rdata_i;
        end else if ((state_q == ST_WR_RESP) && b_hs) begin
            ack_err = (axi_bresp_i != AXI_RESP_OKAY);
        end
    end

    // Request capture and per-channel handshake tracking
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            addr_q    <= 32'h0;
            wdata_q   <= 32'h0;
            wstrb_q   <= 4'h0;
            tag_q     <= '0;
            is_wr_q   <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            ar_done_q <= 1'b0;
        end else if (take) begin
            // Low address bits are zero for legal word-aligned requests; forced so
            // the bus never sees a misaligned word address
            addr_q    <= {mem_addr_i[31:2], 2'b00};
            wdata_q   <= mem_data_wr_i;
            wstrb_q   <= mem_wr_i;
            tag_q     <= mem_req_tag_i;
            is_wr_q   <= req_wr;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            ar_done_q <= 1'b0;
        end else begin
            if (aw_hs) aw_done_q <= 1'b1;
            if (w_hs)  w_done_q  <= 1'b1;
            if (ar_hs) ar_done_q <= 1'b1;
        end
    end

    // Registered one-cycle ack; read data holds between acks
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
            rdata_q    <= 32'h0;
            resp_tag_q <= '0;
        end else begin
            ack_q <= ack_set;
            err_q <= ack_set & ack_err;
            if (ack_set) begin
                rdata_q    <= ack_data;
                resp_tag_q <= tag_q;
            end
        end
    end

    assign mem_ack_o         = ack_q;
    assign mem_error_o       = err_q;
    assign mem_data_rd_o     = rdata_q;
    assign mem_resp_tag_o    = resp_tag_q;
    assign mem_load_fault_o  = 1'b0;
    assign mem_store_fault_o = 1'b0;

    assign axi_awaddr_o = addr_q;
    assign axi_araddr_o = addr_q;
    assign axi_wdata_o  = wdata_q;
    assign axi_wstrb_o  = wstrb_q;
    assign axi_awprot_o = 3'b000;
    assign axi_arprot_o = 3'b000;

    // Cacheability is meaningless on this uncached path
    assign unused_ok = ^{mem_cacheable_i, mem_addr_i[1:0]};

    // The LSU never presents more than one request class at once
    a_single_req_class: assert property (@(posedge clk_i) disable iff (rst_i)
        take |-> $onehot({req_wr, req_rd, req_cmo}));

endmodule
